seg_display_arbiter: RTL

- Shares the single 4-digit seven-segment display among N_REQ requesters, each presenting a 16-bit hex value.
- Round-robin arbitration with a minimum dwell time per owner, so every value stays readable.
- Drives the 16-bit value input of the display multiplexer; that multiplexer keeps its own scan counter.
- Provides per-requester one-hot grant and owner index for LEDs and debug.

---
 rtl/seg_display_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// seg_display_arbiter: round-robin sharing of one 4-digit hex display with a minimum dwell per owner.
// Optional macro SEGARB_GAP_EN inserts a blanked GAP state on every handoff and release.
module seg_display_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000,
  parameter int          GAP_CYCLES  = 262_144
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [16*N_REQ-1:0]      data,
  output logic [N_REQ-1:0]         gnt,
  output logic [15:0]              x,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     active,
  output logic                     blank
);

  localparam int OW = $clog2(N_REQ);
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_MAX  = DW'(HOLD_CYCLES - 1);
  localparam logic [OW-1:0] LAST_RESET = OW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [15:0]       x_q, x_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic              active_q, active_d;
  logic              blank_q, blank_d;
  logic [DW-1:0]     dwell_q, dwell_d;

`ifdef SEGARB_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0]     gap_q, gap_d;
`endif

  logic [15:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_arr[i] = data[16*i +: 16];
  end

  // Returns {found, index} of the first requester at base+1 .. base+span (mod N_REQ).
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [OW-1:0]    base,
                                          input int               span);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (k <= span && r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  logic [OW:0]   any_pick, excl_pick;
  logic          any_found, excl_found;
  logic [OW-1:0] any_idx, excl_idx;
  logic          owner_drop, expired;

  assign any_pick   = rr_pick(req, last_owner_q, N_REQ);
  // In HOLD owner_q equals last_owner_q, so this scan skips the current owner.
  assign excl_pick  = rr_pick(req, owner_q, N_REQ - 1);
  assign any_found  = any_pick[OW];
  assign any_idx    = any_pick[OW-1:0];
  assign excl_found = excl_pick[OW];
  assign excl_idx   = excl_pick[OW-1:0];
  assign owner_drop = ~req[owner_q];
  assign expired    = (dwell_q == DWELL_MAX);

  logic          do_grant, do_idle, do_gap;
  logic [OW-1:0] grant_idx;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    x_d          = x_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    active_d     = active_q;
    blank_d      = blank_q;
    dwell_d      = dwell_q;
`ifdef SEGARB_GAP_EN
    gap_d        = gap_q;
`endif
    do_grant     = 1'b0;
    do_idle      = 1'b0;
    do_gap       = 1'b0;
    grant_idx    = any_idx;

    case (state_q)
      S_IDLE: begin
        if (any_found) begin
          do_grant  = 1'b1;
          grant_idx = any_idx;
        end
      end
      S_HOLD: begin
        x_d = data_arr[owner_q];
        // Owner drop takes priority over a coincident dwell expiry.
        if (owner_drop || expired) begin
          if (excl_found) begin
`ifdef SEGARB_GAP_EN
            do_gap    = 1'b1;
`else
            do_grant  = 1'b1;
            grant_idx = excl_idx;
`endif
          end else if (!owner_drop) begin
            dwell_d = '0;
          end else begin
`ifdef SEGARB_GAP_EN
            do_gap  = 1'b1;
`else
            do_idle = 1'b1;
`endif
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
`ifdef SEGARB_GAP_EN
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (any_found) begin
            do_grant  = 1'b1;
            grant_idx = any_idx;
          end else begin
            do_idle = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d            = S_HOLD;
      gnt_d              = '0;
      gnt_d[grant_idx]   = 1'b1;
      owner_d            = grant_idx;
      last_owner_d       = grant_idx;
      x_d                = data_arr[grant_idx];
      active_d           = 1'b1;
      blank_d            = 1'b0;
      dwell_d            = '0;
    end
    if (do_idle || do_gap) begin
      state_d  = do_gap ? S_GAP : S_IDLE;
      gnt_d    = '0;
      x_d      = IDLE_VALUE;
      owner_d  = '0;
      active_d = 1'b0;
      blank_d  = 1'b1;
      dwell_d  = '0;
`ifdef SEGARB_GAP_EN
      gap_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      x_q          <= IDLE_VALUE;
      owner_q      <= '0;
      last_owner_q <= LAST_RESET;
      active_q     <= 1'b0;
      blank_q      <= 1'b1;
      dwell_q      <= '0;
`ifdef SEGARB_GAP_EN
      gap_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      x_q          <= x_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      active_q     <= active_d;
      blank_q      <= blank_d;
      dwell_q      <= dwell_d;
`ifdef SEGARB_GAP_EN
      gap_q        <= gap_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign x      = x_q;
  assign owner  = owner_q;
  assign active = active_q;
  assign blank  = blank_q;

endmodule
`default_nettype wire
